// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the 16-pin PWM output peripheral.
// Holds counter width, channel count, full-duty code and the pin mux.
package pwm_pkg;

    localparam int PWM_CNT_W = 8;
    localparam int NUM_CH    = 16;

    localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;
    localparam logic [PWM_CNT_W-1:0] CNT_LAST  = 8'hFF;

    // Disabled pin is forced low regardless of its PWM select.
    function automatic logic mux_pin(
        input logic en_out,
        input logic en_pwm,
        input logic sig
    );
        logic r;
        r = 1'b0;
        if (en_out) begin
            r = en_pwm ? sig : 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk into a one-cycle tick every CLK_DIV clocks.
// Ports: clk, rst (sync, active-high), tick (comb from counter).
import pwm_pkg::*;

module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_peripheral.sv
// Shared 8-bit PWM with double-buffered duty driving 16 output pins.
// Ports: clk, rst, enable/PWM-select bytes, pwm_duty_cycle, out, period_start.
import pwm_pkg::*;

module pwm_peripheral #(
    parameter int CLK_DIV = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        en_reg_out_7_0,
    input  logic [7:0]        en_reg_out_15_8,
    input  logic [7:0]        en_reg_pwm_7_0,
    input  logic [7:0]        en_reg_pwm_15_8,
    input  logic [7:0]        pwm_duty_cycle,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic                 tick;
    logic                 boundary;
    logic                 load_pending;
    logic                 pwm_sig;
    logic [PWM_CNT_W-1:0] pwm_cnt;
    logic [PWM_CNT_W-1:0] duty_shadow;
    logic [PWM_CNT_W-1:0] duty_eff;
    logic [NUM_CH-1:0]    en_out;
    logic [NUM_CH-1:0]    en_pwm;
    logic [NUM_CH-1:0]    out_nxt;

    pwm_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign en_out   = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm   = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign boundary = tick && (pwm_cnt == CNT_LAST);

    // On the first cycle after reset the shadow is being loaded on this
    // very edge; use the requested duty directly so the first period
    // already has its full high phase.
    assign duty_eff = load_pending ? pwm_duty_cycle : duty_shadow;
    assign pwm_sig  = (duty_eff == DUTY_FULL) || (pwm_cnt < duty_eff);

    always_comb begin
        out_nxt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_nxt[i] = mux_pin(en_out[i], en_pwm[i], pwm_sig);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out          <= '0;
            period_start <= 1'b0;
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            load_pending <= 1'b1;
        end else begin
            out          <= out_nxt;
            period_start <= boundary;
            load_pending <= 1'b0;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
            if (load_pending || boundary) begin
                duty_shadow <= pwm_duty_cycle;
            end
        end
    end

endmodule

// File: doc/pwm_peripheral.md
Name: pwm_peripheral

Overview:
- Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle) and drives the 16 user output pins.
- Generates one shared 8-bit PWM waveform from a prescaled system clock.
- Per pin, selects forced-low, static-high or PWM.
- Duty is double-buffered so SPI writes never cause glitched periods.

Parameters:
- CLK_DIV, 13, system clocks per PWM counter step (>=1); PWM period = 256*CLK_DIV clocks (~3 kHz at 10 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- en_reg_out_7_0  input  8  output enable, pins 7..0
- en_reg_out_15_8  input  8  output enable, pins 15..8
- en_reg_pwm_7_0  input  8  PWM mode select, pins 7..0
- en_reg_pwm_15_8  input  8  PWM mode select, pins 15..8
- pwm_duty_cycle  input  8  requested duty, 0x00..0xFF
- out  output  16  registered pin drive; bit i = pin i ({15_8, 7_0} ordering)
- period_start  output  1  one-cycle pulse at each PWM period boundary

Behaviour:
- Reset (rst=1 at posedge clk): out=0, period_start=0, prescaler=0, pwm_cnt=0, duty_shadow=0, load_pending=1.
- Prescaler: counts 0..CLK_DIV-1 then wraps. tick=1 when prescaler==CLK_DIV-1. With CLK_DIV=1, tick=1 every cycle.
- pwm_cnt: 8-bit; increments on tick; wraps 255->0.
- Boundary event: tick && pwm_cnt==255.
  - period_start=1 for exactly the following cycle.
  - duty_shadow <= pwm_duty_cycle on the same edge.
- load_pending: on the first non-reset cycle, duty_shadow <= pwm_duty_cycle and load_pending clears, so the initial duty applies without waiting a full period. If load_pending and a boundary event coincide, one load occurs.
- pwm_sig = (duty_shadow==8'hFF) | (pwm_cnt < duty_shadow).
  - Duty 0x00: constantly low.
  - Duty 0xFF: constantly high, no one-step dip.
  - Otherwise high for duty*CLK_DIV clocks per period, starting at the period boundary.
- Per pin i, registered:
  - out[i] <= en_out[i] ? (en_pwm[i] ? pwm_sig : 1) : 0.
  - en_out[i]=0 always wins over en_pwm[i].
- Latency:
  - Enable changes reach out one clock after the input changes. They are not buffered and may cut a period.
  - Duty changes take effect only at the next boundary. Mid-period changes are invisible until then.
  - out lags pwm_cnt by one clock.
- All PWM-mode pins toggle on the same edge; no per-pin phase offset.
- Reset mid-period: all state returns to reset values on that edge. The waveform restarts from pwm_cnt=0 after release.
- Inputs are synchronous to clk; no synchronizers inside this block.

Decomposition:
- Shared package pwm_pkg:
  - PWM_CNT_W=8
  - NUM_CH=16
  - DUTY_FULL=8'hFF
  - function mux_pin(en_out, en_pwm, sig)
- One sub-module: pwm_prescaler.
  - Parameter CLK_DIV; ports clk, rst, tick.
  - Holds the divider counter; tick is combinational from the counter.
- Top holds pwm_cnt, duty_shadow, load_pending, pin mux and output registers.

Test Plan:
- Reset, then all enables 0 and duty 0x80 -> out==16'h0000 for 2 full periods; period_start pulses every 3328 clocks (CLK_DIV=13).
- en_out=16'hFFFF, en_pwm=0 -> out==16'hFFFF from one clock after the write, steady.
- en_out=en_pwm=16'hFFFF, duty 0x80 -> each period high exactly 1664 clocks, low 1664. Duty 0x00 -> always 0. Duty 0xFF -> always 1 across boundaries.
- Duty 0x40 running, change to 0xC0 mid-period at pwm_cnt==100 -> current period keeps 0x40 timing (832 high clocks); next period after period_start is 2496 high.
- en_out=16'h00F0, en_pwm=16'h0030, duty 0x80 -> pins 5,4 PWM; pins 7,6 static 1; pins 15..8 and 3..0 constant 0.
- Assert rst for 1 cycle at pwm_cnt==200 with duty 0x80 -> out=0 next cycle. After release, duty loads immediately and first high phase lasts 1664 clocks from pwm_cnt=0. Repeat with CLK_DIV=1: period 256, high 128.
